// File: rtl/secded_scrub_ctrl.sv
// SECDED (16,11) protected codeword store with host read/write access,
// fault injection and a periodic background scrubber sharing one codec path.
module secded_scrub_ctrl #(
    parameter int ADDR_W       = 4,
    parameter int SCRUB_PERIOD = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [10:0]       req_wdata,
    output logic              resp_valid,
    output logic [10:0]       resp_rdata,
    output logic [1:0]        resp_err,
    input  logic              scrub_en,
    input  logic              inj_valid,
    input  logic [ADDR_W-1:0] inj_addr,
    input  logic [15:0]       inj_mask,
    output logic [7:0]        corr_cnt,
    output logic [7:0]        uncorr_cnt,
    output logic              busy
);

    // Handshake: a host request transfers on a rising edge where req_valid and
    // req_ready are both high; req_ready only rises in IDLE with no injection.

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [15:0] TMR_LAST = 16'(SCRUB_PERIOD - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_CHK,
        ST_WB
    } state_e;

    function automatic logic [3:0] syndrome(input logic [15:0] w);
        logic [3:0] s;
        s = '0;
        for (int i = 1; i < 16; i++) begin
            if (w[i]) s = s ^ 4'(i);
        end
        return s;
    endfunction

    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] w;
        logic [3:0]  s;
        w        = '0;
        w[3]     = d[0];
        w[7:5]   = d[3:1];
        w[15:9]  = d[10:4];
        s        = syndrome(w);
        w[1]     = s[0];
        w[2]     = s[1];
        w[4]     = s[2];
        w[8]     = s[3];
        w[0]     = ^w[15:1];
        return w;
    endfunction

    function automatic logic [10:0] extract(input logic [15:0] w);
        return {w[15:9], w[7:5], w[3]};
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] init_addr_q, init_addr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              scrub_op_q, scrub_op_d;
    logic [15:0]       word_q, word_d;
    logic              resp_valid_q, resp_valid_d;
    logic [10:0]       resp_rdata_q, resp_rdata_d;
    logic [1:0]        resp_err_q, resp_err_d;
    logic [7:0]        corr_cnt_q, corr_cnt_d;
    logic [7:0]        uncorr_cnt_q, uncorr_cnt_d;
    logic [15:0]       tmr_q, tmr_d;
    logic              scrub_pending_q, scrub_pending_d;
    logic [ADDR_W-1:0] scrub_addr_q, scrub_addr_d;

    logic [15:0]       mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [15:0]       mem_wdata;

    logic              start_scrub;
    logic [3:0]        dec_syn;
    logic              dec_par;
    logic [15:0]       dec_fixed;
    logic [1:0]        dec_err;
    logic [10:0]       dec_data;

    assign req_ready  = (state_q == ST_IDLE) && !inj_valid;
    assign busy       = (state_q != ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign corr_cnt   = corr_cnt_q;
    assign uncorr_cnt = uncorr_cnt_q;

    // P=1 means an odd number of flips; the syndrome then names the bad bit,
    // with syndrome 0 pointing at the overall parity bit itself.
    always_comb begin
        dec_syn   = syndrome(word_q);
        dec_par   = ^word_q;
        dec_fixed = word_q ^ (16'd1 << dec_syn);
        if (dec_par) begin
            dec_err  = 2'b01;
            dec_data = extract(dec_fixed);
        end else if (dec_syn != 4'd0) begin
            dec_err  = 2'b10;
            dec_data = extract(word_q);
        end else begin
            dec_err  = 2'b00;
            dec_data = extract(word_q);
        end
    end

    always_comb begin
        state_d      = state_q;
        init_addr_d  = init_addr_q;
        addr_d       = addr_q;
        scrub_op_d   = scrub_op_q;
        word_d       = word_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 2'b00;
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        scrub_addr_d = scrub_addr_q;
        mem_we       = 1'b0;
        mem_waddr    = addr_q;
        mem_wdata    = word_q;
        start_scrub  = 1'b0;

        case (state_q)
            ST_INIT: begin
                mem_we      = 1'b1;
                mem_waddr   = init_addr_q;
                mem_wdata   = '0;
                init_addr_d = init_addr_q + 1'b1;
                if (init_addr_q == LAST_ADDR) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (inj_valid) begin
                    mem_we    = 1'b1;
                    mem_waddr = inj_addr;
                    mem_wdata = mem[inj_addr] ^ inj_mask;
                end else if (req_valid) begin
                    addr_d     = req_addr;
                    scrub_op_d = 1'b0;
                    if (req_we) begin
                        word_d  = encode(req_wdata);
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end else if (scrub_pending_q) begin
                    addr_d      = scrub_addr_q;
                    scrub_op_d  = 1'b1;
                    start_scrub = 1'b1;
                    state_d     = ST_RD;
                end
            end
            ST_WR: begin
                mem_we       = 1'b1;
                resp_valid_d = 1'b1;
                state_d      = ST_IDLE;
            end
            ST_RD: begin
                word_d  = mem[addr_q];
                state_d = ST_CHK;
            end
            ST_CHK: begin
                if (scrub_op_q) begin
                    scrub_addr_d = scrub_addr_q + 1'b1;
                end else begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = dec_data;
                    resp_err_d   = dec_err;
                end
                state_d = ST_IDLE;
                if (dec_err == 2'b01) begin
                    word_d  = dec_fixed;
                    state_d = ST_WB;
                    if (corr_cnt_q != 8'hFF) corr_cnt_d = corr_cnt_q + 8'd1;
                end else if (dec_err == 2'b10) begin
                    if (uncorr_cnt_q != 8'hFF) uncorr_cnt_d = uncorr_cnt_q + 8'd1;
                end
            end
            ST_WB: begin
                mem_we  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // A terminal count that lands while a scrub is already pending merges into it.
    always_comb begin
        tmr_d           = tmr_q;
        scrub_pending_d = scrub_pending_q;
        if (!scrub_en) begin
            tmr_d           = '0;
            scrub_pending_d = 1'b0;
        end else begin
            if (start_scrub) scrub_pending_d = 1'b0;
            if (tmr_q == TMR_LAST) begin
                tmr_d           = '0;
                scrub_pending_d = 1'b1;
            end else begin
                tmr_d = tmr_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_INIT;
            init_addr_q     <= '0;
            addr_q          <= '0;
            scrub_op_q      <= 1'b0;
            word_q          <= '0;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= '0;
            resp_err_q      <= 2'b00;
            corr_cnt_q      <= '0;
            uncorr_cnt_q    <= '0;
            tmr_q           <= '0;
            scrub_pending_q <= 1'b0;
            scrub_addr_q    <= '0;
        end else begin
            state_q         <= state_d;
            init_addr_q     <= init_addr_d;
            addr_q          <= addr_d;
            scrub_op_q      <= scrub_op_d;
            word_q          <= word_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_err_q      <= resp_err_d;
            corr_cnt_q      <= corr_cnt_d;
            uncorr_cnt_q    <= uncorr_cnt_d;
            tmr_q           <= tmr_d;
            scrub_pending_q <= scrub_pending_d;
            scrub_addr_q    <= scrub_addr_d;
        end
    end

    // The store has no reset; INIT rewrites every word after rst.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
    end

endmodule

// File: tb/tb_secded_scrub_ctrl.sv
// Randomised scoreboard bench for secded_scrub_ctrl against a position-table
// Hamming reference model of the store, counters and response timing.
module tb_secded_scrub_ctrl;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int PER    = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [10:0]       req_wdata = '0;
    logic              resp_valid;
    logic [10:0]       resp_rdata;
    logic [1:0]        resp_err;
    logic              scrub_en = 1'b0;
    logic              inj_valid = 1'b0;
    logic [ADDR_W-1:0] inj_addr = '0;
    logic [15:0]       inj_mask = '0;
    logic [7:0]        corr_cnt;
    logic [7:0]        uncorr_cnt;
    logic              busy;

    secded_scrub_ctrl #(.ADDR_W(ADDR_W), .SCRUB_PERIOD(PER)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .scrub_en(scrub_en), .inj_valid(inj_valid), .inj_addr(inj_addr),
        .inj_mask(inj_mask), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    logic [12:0] exp_q[$];
    int          exp_cyc_q[$];

    logic [15:0] mmem [DEPTH];
    int          m_corr;
    int          m_uncorr;
    int          dpos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: data bits placed by table, each parity bit covers the
    // positions whose index has that bit set, p0 makes the word even.
    function automatic logic [15:0] m_encode(input logic [10:0] d);
        logic [15:0] w;
        w = '0;
        for (int k = 0; k < 11; k++) w[dpos[k]] = d[k];
        for (int p = 0; p < 4; p++) begin
            logic b;
            b = 1'b0;
            for (int j = 1; j < 16; j++)
                if (((j >> p) & 1) == 1 && j != (1 << p)) b = b ^ w[j];
            w[1 << p] = b;
        end
        w[0] = ($countones(w[15:1]) % 2) == 1;
        return w;
    endfunction

    task automatic m_decode(input logic [15:0] w, output logic [10:0] d,
                            output logic [1:0] err, output logic [15:0] fixed);
        int s;
        int par;
        s = 0;
        for (int p = 0; p < 4; p++) begin
            int ones;
            ones = 0;
            for (int j = 1; j < 16; j++)
                if (((j >> p) & 1) == 1 && w[j]) ones++;
            if (ones % 2 == 1) s = s + (1 << p);
        end
        par = $countones(w) % 2;
        fixed = w;
        if (par == 1) begin
            fixed[s] = ~fixed[s];
            err = 2'b01;
        end else if (s != 0) begin
            err = 2'b10;
        end else begin
            err = 2'b00;
        end
        for (int k = 0; k < 11; k++) d[k] = fixed[dpos[k]];
    endtask

    logic [12:0] mon_e;
    int          mon_c;
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = exp_cyc_q.pop_front();
                check("resp_data_err", {19'd0, resp_err, resp_rdata}, {19'd0, mon_e});
                check("resp_cycle", cyc, mon_c);
            end
        end
    end

    task automatic do_reset();
        int n;
        rst = 1'b1;
        req_valid = 1'b0;
        inj_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_busy", busy, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_corr_cnt", corr_cnt, 0);
        check("rst_uncorr_cnt", uncorr_cnt, 0);
        exp_q.delete();
        exp_cyc_q.delete();
        for (int a = 0; a < DEPTH; a++) mmem[a] = m_encode(11'd0);
        m_corr = 0;
        m_uncorr = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!req_ready && n < 100);
        check("init_cycles", n, 16);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = req_ready;
        if (!ok) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic host_op(input logic we, input logic [ADDR_W-1:0] a,
                           input logic [10:0] wd, input bit timed);
        bit ok;
        int t;
        int idle_at;
        int n;
        logic [10:0] d;
        logic [1:0]  err;
        logic [15:0] fixed;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        wait_ready(ok);
        @(posedge clk);
        #1;
        t = cyc;
        req_valid = 1'b0;
        if (!ok) return;
        if (we) begin
            mmem[a] = m_encode(wd);
            exp_q.push_back({2'b00, 11'd0});
            exp_cyc_q.push_back(t + 1);
            idle_at = t + 1;
        end else begin
            m_decode(mmem[a], d, err, fixed);
            exp_q.push_back({err, d});
            exp_cyc_q.push_back(t + 2);
            idle_at = t + 2;
            if (err == 2'b01) begin
                mmem[a] = fixed;
                if (m_corr < 255) m_corr++;
                idle_at = t + 3;
            end else if (err == 2'b10) begin
                if (m_uncorr < 255) m_uncorr++;
            end
        end
        n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (timed) begin
            check("ready_return_cycle", cyc, idle_at);
            check("ready_after_op", req_ready, 1);
            check("corr_cnt", corr_cnt, m_corr);
            check("uncorr_cnt", uncorr_cnt, m_uncorr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic inject(input logic [ADDR_W-1:0] a, input logic [15:0] mask);
        inj_valid = 1'b1;
        inj_addr  = a;
        inj_mask  = mask;
        @(negedge clk);
        check("inj_blocks_ready", req_ready, 0);
        @(posedge clk);
        #1 inj_valid = 1'b0;
        mmem[a] = mmem[a] ^ mask;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;
        int bc;
        int t;
        logic [15:0] mask;
        logic [10:0] d;
        logic [1:0]  err;
        logic [15:0] fixed;

        do_reset();

        host_op(1'b0, 4'd0, 11'd0, 1'b1);
        host_op(1'b0, 4'd7, 11'd0, 1'b1);
        host_op(1'b0, 4'd15, 11'd0, 1'b1);

        host_op(1'b1, 4'd2, 11'h001, 1'b1);
        check("stored_word_addr2", dut.mem[2], 16'h000F);
        host_op(1'b0, 4'd2, 11'd0, 1'b1);

        inject(4'd2, 16'h0008);
        host_op(1'b0, 4'd2, 11'd0, 1'b1);
        host_op(1'b0, 4'd2, 11'd0, 1'b1);
        inject(4'd2, 16'h0001);
        host_op(1'b0, 4'd2, 11'd0, 1'b1);
        inject(4'd2, 16'h0018);
        host_op(1'b0, 4'd2, 11'd0, 1'b1);
        host_op(1'b0, 4'd2, 11'd0, 1'b1);
        check("uncorr_after_double", uncorr_cnt, 2);

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 2))
                0: host_op(1'b1, 4'($urandom_range(0, DEPTH - 1)), 11'($urandom), 1'b1);
                1: host_op(1'b0, 4'($urandom_range(0, DEPTH - 1)), 11'd0, 1'b1);
                default: begin
                    mask = '0;
                    for (int k = $urandom_range(1, 3); k > 0; k--)
                        mask[$urandom_range(0, 15)] = 1'b1;
                    inject(4'($urandom_range(0, DEPTH - 1)), mask);
                end
            endcase
        end

        // Reset lands right after a read transfer: no response, INIT reruns.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'd3;
        wait_ready(ok);
        @(posedge clk);
        #1 req_valid = 1'b0;
        do_reset();
        host_op(1'b0, 4'd2, 11'd0, 1'b1);

        for (int a = 0; a < DEPTH; a++) host_op(1'b1, 4'(a), 11'($urandom), 1'b1);
        inject(4'd5, 16'h8000);
        scrub_en = 1'b1;
        n = 0;
        @(negedge clk);
        while (corr_cnt == 8'(m_corr) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (m_corr < 255) m_corr++;
        m_decode(mmem[5], d, err, fixed);
        mmem[5] = fixed;
        check("scrub_corr_cnt", corr_cnt, m_corr);

        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'd5;
        bc = 1;
        check("ready_low_in_scrub", req_ready, 0);
        @(negedge clk);
        while (busy && bc < 20) begin
            check("ready_low_in_scrub", req_ready, 0);
            bc++;
            @(negedge clk);
        end
        check("scrub_occupancy", bc, 2);
        check("ready_after_scrub", req_ready, 1);
        @(posedge clk);
        #1;
        t = cyc;
        req_valid = 1'b0;
        m_decode(mmem[5], d, err, fixed);
        exp_q.push_back({err, d});
        exp_cyc_q.push_back(t + 2);
        check("addr5_clean_model", err, 0);
        repeat (4) @(posedge clk);
        #1 scrub_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("scrub_corr_stable", corr_cnt, m_corr);

        for (int i = 0; i < 300; i++) begin
            logic [ADDR_W-1:0] a;
            a = 4'($urandom_range(0, DEPTH - 1));
            mask = 16'd1 << $urandom_range(0, 15);
            inject(a, mask);
            host_op(1'b0, a, 11'd0, 1'b1);
        end
        check("corr_cnt_saturated", corr_cnt, 255);

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
